// File: rtl/board_score_counter_if.sv
// Board RAM read port: strobe plus cell address out, cell code back one cycle later.
interface board_score_counter_if;
    logic       rd_en;
    logic [2:0] rd_x;
    logic [2:0] rd_y;
    logic [1:0] rd_q;

    modport master (output rd_en, output rd_x, output rd_y, input rd_q);
    modport slave  (input rd_en, input rd_x, input rd_y, output rd_q);
endinterface

// File: rtl/board_score_counter.sv
// Scans all board cells and publishes black/white/empty totals; done 66 cycles after start.
// No backpressure: starts arriving while busy collapse into a single pending rescan.
module board_score_counter #(
    parameter int         BOARD_DIM  = 8,
    parameter logic [1:0] SIDE_BLACK = 2'b01,
    parameter logic [1:0] SIDE_WHITE = 2'b10
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    board_score_counter_if.master        rd,
    output logic [6:0]                   black_count,
    output logic [6:0]                   white_count,
    output logic [6:0]                   empty_count,
    output logic [1:0]                   leader,
    output logic                         board_full,
    output logic                         busy,
    output logic                         done
);

    localparam logic [5:0] LAST_IDX = 6'(BOARD_DIM * BOARD_DIM - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, PUBLISH} state_t;

    state_t     state, state_nxt;
    logic [5:0] idx;
    logic [6:0] acc_black, acc_white, acc_empty;
    logic [6:0] sum_black, sum_white, sum_empty;
    logic       pending;
    logic       q_vld;
    logic       rescan;

    // rd_q lags rd_en by one cycle, so q_vld marks the cycle a cell code is present.
    always_comb begin
        sum_black = acc_black;
        sum_white = acc_white;
        sum_empty = acc_empty;
        if (q_vld) begin
            if (rd.rd_q == SIDE_BLACK)
                sum_black = acc_black + 7'd1;
            else if (rd.rd_q == SIDE_WHITE)
                sum_white = acc_white + 7'd1;
            else
                sum_empty = acc_empty + 7'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        rd.rd_en  = 1'b0;
        rd.rd_x   = 3'd0;
        rd.rd_y   = 3'd0;
        rescan    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = SCAN;
                    rescan    = 1'b1;
                end
            end
            SCAN: begin
                rd.rd_en = 1'b1;
                rd.rd_x  = idx[2:0];
                rd.rd_y  = idx[5:3];
                if (idx == LAST_IDX)
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = PUBLISH;
            PUBLISH: begin
                if (pending || start) begin
                    state_nxt = SCAN;
                    rescan    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state       <= IDLE;
            idx         <= 6'd0;
            acc_black   <= 7'd0;
            acc_white   <= 7'd0;
            acc_empty   <= 7'd0;
            pending     <= 1'b0;
            q_vld       <= 1'b0;
            black_count <= 7'd0;
            white_count <= 7'd0;
            empty_count <= 7'd64;
            leader      <= 2'b00;
            board_full  <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_nxt;
            q_vld <= (state == SCAN);
            done  <= (state == DRAIN);

            if (state == PUBLISH)
                pending <= 1'b0;
            else if (start && state != IDLE)
                pending <= 1'b1;

            if (rescan) begin
                idx       <= 6'd0;
                acc_black <= 7'd0;
                acc_white <= 7'd0;
                acc_empty <= 7'd0;
            end else begin
                if (state == SCAN)
                    idx <= idx + 6'd1;
                if (q_vld) begin
                    acc_black <= sum_black;
                    acc_white <= sum_white;
                    acc_empty <= sum_empty;
                end
            end

            // Registering the final sums here makes them visible together with done.
            if (state == DRAIN) begin
                black_count <= sum_black;
                white_count <= sum_white;
                empty_count <= sum_empty;
                board_full  <= (sum_empty == 7'd0);
                if (sum_black > sum_white)
                    leader <= 2'b01;
                else if (sum_white > sum_black)
                    leader <= 2'b10;
                else
                    leader <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_board_score_counter.sv
// Directed bench for board_score_counter with a one-cycle-latency board RAM model.
module tb_board_score_counter;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic [6:0] black_count, white_count, empty_count;
    logic [1:0] leader;
    logic       board_full, busy, done;

    logic [1:0] board      [64];
    logic [1:0] board_next [64];
    int         swap_at = -1;

    int errors = 0;
    int checks = 0;

    board_score_counter_if bus ();

    board_score_counter dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .rd          (bus.master),
        .black_count (black_count),
        .white_count (white_count),
        .empty_count (empty_count),
        .leader      (leader),
        .board_full  (board_full),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (bus.rd_en)
            bus.rd_q <= board[{bus.rd_y, bus.rd_x}];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Fill order: n11 cells of code 11, then nb black, then nw white, rest 00.
    task automatic set_board(input int nb, input int nw, input int n11);
        for (int i = 0; i < 64; i++) begin
            if (i < n11)                board[i] = 2'b11;
            else if (i < n11 + nb)      board[i] = 2'b01;
            else if (i < n11 + nb + nw) board[i] = 2'b10;
            else                        board[i] = 2'b00;
        end
    endtask

    task automatic init_board();
        set_board(0, 0, 0);
        board[27] = 2'b10;
        board[36] = 2'b10;
        board[35] = 2'b01;
        board[28] = 2'b01;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_black"}, black_count, 0);
        check({tag, "_white"}, white_count, 0);
        check({tag, "_empty"}, empty_count, 64);
        check({tag, "_leader"}, leader, 0);
        check({tag, "_full"}, board_full, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rd_en"}, bus.rd_en, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Start is sampled at edge N; loop index j is cycle N+j, sampled at its falling edge.
    task automatic run_scan(input int start_again, input int reset_at, input bit hold,
                            input int window, output int rd_cnt, output int addr_bad,
                            output int n_done, output int d1, output int d2,
                            output int first_black, output int first_empty);
        rd_cnt = 0; addr_bad = 0; n_done = 0; d1 = 0; d2 = 0;
        first_black = -1; first_empty = -1;
        @(negedge clock);
        start = 1'b1;
        for (int j = 1; j <= window; j++) begin
            @(negedge clock);
            if (bus.rd_en) begin
                rd_cnt++;
                if ({bus.rd_y, bus.rd_x} != 6'((j - 1) % 66))
                    addr_bad++;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    d1 = j;
                    first_black = int'(black_count);
                    first_empty = int'(empty_count);
                end else if (n_done == 2) begin
                    d2 = j;
                end
            end
            if (j == swap_at)
                board = board_next;
            if (j == reset_at) begin
                resetn = 1'b1;
                #1;
                check_reset_outputs("midreset");
            end
            if (j == reset_at + 1)
                resetn = 1'b0;
            start = hold || (j == start_again);
        end
        start = 1'b0;
    endtask

    task automatic single_scan(input string tag, input int eb, input int ew, input int ee,
                               input int el, input int ef);
        int rc, ab, nd, d1, d2, fb, fe;
        run_scan(-1, -1, 1'b0, 70, rc, ab, nd, d1, d2, fb, fe);
        check({tag, "_rd_cycles"}, rc, 64);
        check({tag, "_addr_order"}, ab, 0);
        check({tag, "_done_count"}, nd, 1);
        check({tag, "_done_cycle"}, d1, 66);
        check({tag, "_black_at_done"}, fb, eb);
        check({tag, "_black"}, black_count, eb);
        check({tag, "_white"}, white_count, ew);
        check({tag, "_empty"}, empty_count, ee);
        check({tag, "_leader"}, leader, el);
        check({tag, "_full"}, board_full, ef);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int rc, ab, nd, d1, d2, fb, fe;

        init_board();
        #12;
        check_reset_outputs("reset");
        @(negedge clock);
        resetn = 1'b0;

        init_board();
        single_scan("init", 2, 2, 60, 0, 0);

        set_board(40, 24, 0);
        single_scan("b40w24", 40, 24, 0, 1, 1);

        set_board(10, 54, 0);
        single_scan("b10w54", 10, 54, 0, 2, 1);

        set_board(5, 0, 3);
        single_scan("code11", 5, 0, 59, 1, 0);

        // Restart request mid-scan; board swapped to all black before the rescan reads it.
        set_board(64, 0, 0);
        board_next = board;
        init_board();
        swap_at = 66;
        run_scan(20, -1, 1'b0, 140, rc, ab, nd, d1, d2, fb, fe);
        swap_at = -1;
        check("dbl_done_count", nd, 2);
        check("dbl_done1", d1, 66);
        check("dbl_done2", d2, 132);
        check("dbl_rd_cycles", rc, 128);
        check("dbl_addr_order", ab, 0);
        check("dbl_first_black", fb, 2);
        check("dbl_first_empty", fe, 60);
        check("dbl_black", black_count, 64);
        check("dbl_empty", empty_count, 0);
        check("dbl_leader", leader, 1);
        check("dbl_full", board_full, 1);

        set_board(0, 64, 0);
        run_scan(-1, 30, 1'b0, 70, rc, ab, nd, d1, d2, fb, fe);
        check("rst_done_count", nd, 0);
        check("rst_black_hold", black_count, 0);
        check("rst_empty_hold", empty_count, 64);
        init_board();
        single_scan("post_rst", 2, 2, 60, 0, 0);

        set_board(0, 64, 0);
        run_scan(-1, -1, 1'b1, 133, rc, ab, nd, d1, d2, fb, fe);
        check("hold_done1", d1, 66);
        check("hold_done2", d2, 132);
        check("hold_done_count", nd, 2);
        check("hold_white", white_count, 64);
        check("hold_leader", leader, 2);
        repeat (200) @(negedge clock);
        check("hold_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/board_score_counter.md
Name: board_score_counter

Overview:
- Downstream consumer of the board RAM and the game controller.
- After each placed or flipped turn, it scans all 64 board cells through a read port and counts black, white and empty cells.
- It publishes stable totals, a leader code and a board-full flag. These drive the score digits on HEX4/HEX5 and the controller's win input.

Parameters:
- BOARD_DIM, 8, cells per row/column; the scan covers BOARD_DIM*BOARD_DIM cells, index width 3 per axis.
- SIDE_BLACK, 2'b01, cell code counted as black.
- SIDE_WHITE, 2'b10, cell code counted as white.

Ports:
- clock  in  1  system clock (CLOCK_50).
- resetn  in  1  asynchronous, active-high reset (driven by restart).
- start  in  1  request a rescan; sampled on the rising edge; level or pulse.
- rd_en  out  1  board read strobe.
- rd_x  out  3  cell column address.
- rd_y  out  3  cell row address.
- rd_q  in  2  cell contents; valid the cycle after rd_en (fixed 1-cycle read latency).
- black_count  out  7  published black total, 0..64.
- white_count  out  7  published white total, 0..64.
- empty_count  out  7  published count of all other codes, 0..64.
- leader  out  2  01 black ahead, 10 white ahead, 00 tie.
- board_full  out  1  empty_count == 0.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the published outputs update.

Behaviour:
Reset (async, active-high): all outputs take these values immediately, and any in-flight scan is abandoned with no done pulse.
- black_count=0, white_count=0, empty_count=64.
- leader=00, board_full=0, busy=0, done=0.
- rd_en=0, rd_x=0, rd_y=0.
- Internal accumulators and the pending flag clear.

FSM states:
- IDLE: busy=0. On start=1 → SCAN, with index=0 and accumulators cleared.
- SCAN: rd_en=1, rd_x=index[2:0], rd_y=index[5:3] (x fastest, row-major). Each cycle, the rd_q returned for the previous index is accumulated. At index 63 → DRAIN; otherwise index+1.
- DRAIN: rd_en=0. Accumulates the rd_q for index 63. → PUBLISH.
- PUBLISH:
  - Copy the accumulators to the count outputs.
  - Compute leader by comparing black vs white.
  - Set board_full = (empty==0).
  - Pulse done=1 for this cycle only.
  - → SCAN if pending=1 (clear pending, reset index and accumulators); else → IDLE.

Classification of rd_q:
- SIDE_BLACK → black+1.
- SIDE_WHITE → white+1.
- Every other code (00, 11) → empty+1.

Timing:
- If start is sampled at edge N, rd_en is high in cycles N+1..N+64, covering addresses 0..63 in order.
- done is high in cycle N+66. Outputs are valid from that cycle and hold until the next PUBLISH.

Invariants:
- busy=1 in SCAN, DRAIN and PUBLISH.
- Published black+white+empty == 64 always.
- Outputs never change except in PUBLISH or on reset, so no partial totals are ever visible.

Boundary cases:
- start while busy (any state except IDLE) sets pending. Multiple starts collapse to one rescan.
- start in the PUBLISH cycle sets pending, so the rescan follows immediately.
- Accumulators are 7 bits and cannot overflow, since the maximum is 64.
- An all-white or all-black board gives a count of 64, board_full=1, and leader 10 or 01.
- If start is held high continuously, scans run back-to-back, with a done pulse every 66 cycles.

Test Plan:
- Reset → counts 0/0/64, leader=00, board_full=0, busy=0, rd_en=0.
- Initial board (centre (3,3),(4,4)=white; (3,4),(4,3)=black), start pulse at edge N:
  - rd_en high N+1..N+64 with addresses 0..63 in row-major order.
  - done at N+66.
  - Counts 2/2/60, leader=00, board_full=0.
- Full board with 40 black and 24 white → 40/24/0, leader=01, board_full=1. Then 10 black and 54 white → leader=10.
- Board containing 3 cells of code 2'b11 plus 5 black and 0 white → 5/0/59; codes 11 are counted as empty.
- start pulse again at cycle N+20 of an active scan:
  - First done at N+66 with totals for the board as read.
  - Rescan begins at N+67, with a second done at N+132.
  - Exactly two done pulses.
- Assert resetn at cycle N+30 mid-scan → outputs return to reset values immediately, with no done pulse. A new start after release gives correct totals with no carry-over.
